nanop_out_port: RTL and testbench

- Output peripheral directly downstream of the nanoprocessor's OUT instruction.
- Each byte written by the core is captured in a small FIFO, then serialised on a UART TX line (8N1, LSB first).
- The core never stalls. The block therefore absorbs bursts and flags overflow instead of back-pressuring.

---
 rtl/nanop_pkg.sv | 21 ++
 rtl/nanop_out_fifo.sv | 48 ++++
 rtl/nanop_out_port.sv | 146 ++++++++++++++
 tb/tb_nanop_out_port.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanop_pkg.sv
// Shared nanoprocessor definitions: opcode encodings and the OUT-port TX state type.
package nanop_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_MOV  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_AND  = 8'h05;
  localparam logic [7:0] OP_OR   = 8'h06;
  localparam logic [7:0] OP_XOR  = 8'h07;
  localparam logic [7:0] OP_LD   = 8'h08;
  localparam logic [7:0] OP_ST   = 8'h09;
  localparam logic [7:0] OP_JMP  = 8'h0A;
  localparam logic [7:0] OP_JZ   = 8'h0B;
  localparam logic [7:0] OP_OUT  = 8'h0C;
  localparam logic [7:0] OP_HALT = 8'h0F;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

endpackage

// File: rtl/nanop_out_fifo.sv
// Byte FIFO for the OUT port; caller guarantees no push when full (unless popping) and no pop when empty.
module nanop_out_fifo
  import nanop_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign level = cnt;
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/nanop_out_port.sv
// OUT-instruction peripheral: FIFO-buffered UART TX (8N1), sticky overflow on dropped writes.
// Define NANOP_OUT_PARITY_EN for an even-parity 8E1 frame.
module nanop_out_port
  import nanop_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   out_we,
  input  logic [7:0]             out_data,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d;
  logic          cnt_last;
  logic          pop, push_ok, ovf_set;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
`ifdef NANOP_OUT_PARITY_EN
  logic          par_q, par_d;
`endif

  assign push_ok  = out_we & (~fifo_full | pop);
  assign ovf_set  = out_we & fifo_full & ~pop;
  assign cnt_last = (cnt_q == CNT_LAST);

  nanop_out_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_ok),
    .pop     (pop),
    .din     (out_data),
    .dout    (fifo_dout),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else cnt_d = cnt_q + 1'b1;
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef NANOP_OUT_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else bit_d = bit_q + 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
`ifdef NANOP_OUT_PARITY_EN
      PARITY: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = STOP;
        end else cnt_d = cnt_q + 1'b1;
      end
`endif
      STOP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

`ifdef NANOP_OUT_PARITY_EN
    par_d = pop ? ^fifo_dout : par_q;
`endif

    // tx is registered from the next-state values so it changes on the same edge as the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef NANOP_OUT_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
`ifdef NANOP_OUT_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
`ifdef NANOP_OUT_PARITY_EN
      par_q   <= par_d;
`endif
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign busy = (level != '0) | (state_q != IDLE);

endmodule

// File: tb/tb_nanop_out_port.sv
// Directed bench for nanop_out_port with CLK_DIV=4, DEPTH=8; honours NANOP_OUT_PARITY_EN.
module tb_nanop_out_port;

  localparam int unsigned CD = 4;
`ifdef NANOP_OUT_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif
  localparam int unsigned FRAME  = NB * CD;
  localparam int unsigned PERIOD = FRAME + 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       out_we;
  logic [7:0] out_data;
  logic       ovf_clr;
  logic       tx;
  logic       busy;
  logic [3:0] level;
  logic       overflow;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  nanop_out_port #(.CLK_DIV(CD), .DEPTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .out_we   (out_we),
    .out_data (out_data),
    .tx       (tx),
    .busy     (busy),
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial receiver: samples each bit two cycles into its period.
  logic            mon_en = 1'b0;
  logic [7:0]      rx_d[$];
  logic            rx_s[$];
  logic            rx_p[$];
  int unsigned     rx_t[$];
  logic [7:0]      m_b;
  logic            m_p, m_s;
  int unsigned     m_t;

  always begin
    @(negedge clk);
    if (mon_en && reset_n && tx === 1'b0) begin
      m_t = cyc;
      m_p = 1'b0;
      repeat (CD/2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CD) @(negedge clk);
        m_b[k] = tx;
      end
`ifdef NANOP_OUT_PARITY_EN
      repeat (CD) @(negedge clk);
      m_p = tx;
`endif
      repeat (CD) @(negedge clk);
      m_s = tx;
      rx_d.push_back(m_b);
      rx_s.push_back(m_s);
      rx_p.push_back(m_p);
      rx_t.push_back(m_t);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_seq(input logic [7:0] first, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      out_we   = 1'b1;
      out_data = first + 8'(i);
    end
    @(negedge clk);
    out_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int unsigned k;
    k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(name, busy, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] exp_q[$];

  task automatic check_drain(input string name, input int unsigned base);
    int unsigned n;
    check({name, " count"}, rx_d.size() - base, exp_q.size());
    n = rx_d.size() - base;
    if (n > exp_q.size()) n = exp_q.size();
    for (int unsigned i = 0; i < n; i++) begin
      check($sformatf("%s byte%0d", name, i), rx_d[base+i], exp_q[i]);
      check($sformatf("%s stop%0d", name, i), rx_s[base+i], 1'b1);
`ifdef NANOP_OUT_PARITY_EN
      check($sformatf("%s par%0d", name, i), rx_p[base+i], ^exp_q[i]);
`endif
      if (i > 0)
        check($sformatf("%s gap%0d", name, i), rx_t[base+i] - rx_t[base+i-1], PERIOD);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // {stop, data[7:0], start}, bit 0 sent first
    logic       par;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int unsigned base;
    logic        ok;
    logic        exp_bit;
    logic        act_bit;

    vecs[0] = '{8'hA5, 10'h34A, 1'b0};
    vecs[1] = '{8'h00, 10'h200, 1'b0};
    vecs[2] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[3] = '{8'h3C, 10'h278, 1'b0};
    vecs[4] = '{8'h81, 10'h302, 1'b0};
    vecs[5] = '{8'h07, 10'h20E, 1'b1};
    vecs[6] = '{8'h03, 10'h206, 1'b0};

    reset_n  = 1'b0;
    out_we   = 1'b0;
    out_data = '0;
    ovf_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst tx", tx, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst level", level, 4'd0);
    check("rst overflow", overflow, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Single-byte frames with exact cycle-by-cycle tx checks.
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      out_we   = 1'b1;
      out_data = vecs[v].data;
      @(negedge clk);
      out_we = 1'b0;
      check($sformatf("v%0d level after push", v), level, 4'd1);
      check($sformatf("v%0d tx before start", v), tx, 1'b1);
      for (int unsigned i = 0; i < NB; i++) begin
        if (i < 9)                exp_bit = vecs[v].frame[i];
        else if (NB == 11 && i == 9) exp_bit = vecs[v].par;
        else                      exp_bit = vecs[v].frame[9];
        ok = 1'b1;
        act_bit = exp_bit;
        for (int unsigned c = 0; c < CD; c++) begin
          @(negedge clk);
          if (tx !== exp_bit && ok) begin
            ok = 1'b0;
            act_bit = tx;
          end
        end
        check($sformatf("v%0d bit%0d", v, i), act_bit, exp_bit);
      end
      check($sformatf("v%0d busy end of stop", v), busy, 1'b1);
      @(negedge clk);
      check($sformatf("v%0d busy after frame", v), busy, 1'b0);
      check($sformatf("v%0d tx idle", v), tx, 1'b1);
    end
    repeat (4) @(negedge clk);

    // Burst of 8: first byte pops immediately, so level peaks at 7.
    base = rx_d.size();
    write_seq(8'h00, 8);
    check("burst level peak", level, 4'd7);
    check("burst overflow", overflow, 1'b0);
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    wait_idle("burst drain");
    check_drain("burst", base);
    check("burst overflow end", overflow, 1'b0);

    // Full FIFO with a write on the exact pop edge: accepted, no overflow.
    base = rx_d.size();
    write_seq(8'h40, 9);
    check("full level", level, 4'd8);
    repeat (FRAME - 7) @(negedge clk);
    check("full level before pop", level, 4'd8);
    out_we   = 1'b1;
    out_data = 8'h49;
    @(negedge clk);
    out_we = 1'b0;
    check("full+pop level", level, 4'd8);
    check("full+pop overflow", overflow, 1'b0);
    exp_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
    wait_idle("full+pop drain");
    check_drain("fullpop", base);

    // Overflow: TX busy with 0x11 while 10 more bytes arrive; last two dropped.
    base = rx_d.size();
    write_seq(8'h11, 1);
    check("ovf pre overflow", overflow, 1'b0);
    write_seq(8'h20, 10);
    check("ovf level sat", level, 4'd8);
    check("ovf flag set", overflow, 1'b1);
    repeat (3) @(negedge clk);
    check("ovf sticky", overflow, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf cleared", overflow, 1'b0);
    exp_q = '{8'h11, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
    wait_idle("ovf drain");
    check_drain("ovf", base);

    // Set wins over a simultaneous clear.
    write_seq(8'h11, 1);
    write_seq(8'h30, 8);
    ovf_clr  = 1'b1;
    out_we   = 1'b1;
    out_data = 8'hEE;
    @(negedge clk);
    out_we  = 1'b0;
    ovf_clr = 1'b0;
    check("ovf set beats clr", overflow, 1'b1);
    wait_idle("setclr drain");
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;

    // Reset asserted during DATA bit 3 of 0x52 (bit 3 = 0).
    mon_en = 1'b0;
    write_seq(8'h52, 1);
    write_seq(8'h77, 1);
    repeat (16) @(negedge clk);
    check("mid tx bit3", tx, 1'b0);
    check("mid level", level, 4'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async rst tx", tx, 1'b1);
    check("async rst level", level, 4'd0);
    check("async rst busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check("post rst quiet", ok, 1'b1);
    check("post rst overflow", overflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
